// File: rtl/axi_sram_slave.sv
// SRAM responder for the LSU data bus: independent AXI-lite-style read and write
// FSMs with byte strobes, address range checking and optional LFSR response delay.
module axi_sram_slave #(
    parameter int unsigned         DATA_LEN     = 32,
    parameter int unsigned         DATA_BIT_NUM = 4,
    parameter int unsigned         DEPTH_LOG2   = 10,
    parameter logic [DATA_LEN-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter bit                  RAND_DELAY   = 1'b0,
    parameter int unsigned         DELAY_BITS   = 3,
    parameter logic [7:0]          RD_SEED      = 8'h01,
    parameter logic [7:0]          WR_SEED      = 8'h5A
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_LEN-1:0]     waddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_BIT_NUM-1:0] wstrob,
    input  logic [DATA_LEN-1:0]     wdata,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [2:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [DATA_LEN-1:0]     raddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [2:0]              rresp,
    output logic [DATA_LEN-1:0]     rdata
);

    localparam logic [2:0]        RESP_OKAY = 3'b000;
    localparam logic [2:0]        RESP_ERR  = 3'b010;
    localparam logic [DATA_LEN:0] ADDR_LO   = {1'b0, BASE_ADDR};
    localparam logic [DATA_LEN:0] SPAN      = {{DATA_LEN{1'b0}}, 1'b1} << (DEPTH_LOG2 + 2);
    localparam logic [DATA_LEN:0] ADDR_HI   = ADDR_LO + SPAN;

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} wstate_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[4] ^ l[3] ^ l[2] ^ l[0], l[7:1]};
    endfunction

    logic [DATA_LEN-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    // ---------------- read channel state ----------------
    rstate_t               rstate_q, rstate_d;
    logic [DATA_LEN-1:0]   raddr_q, raddr_d;
    logic [DELAY_BITS-1:0] rcnt_q, rcnt_d;
    logic [7:0]            rlfsr_q, rlfsr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_LEN-1:0]   rdata_q, rdata_d;
    logic [2:0]            rresp_q, rresp_d;
    logic                  rd_in_range;
    logic [DEPTH_LOG2-1:0] ridx;

    // ---------------- write channel state ----------------
    wstate_t                 wstate_q, wstate_d;
    logic                    aw_got_q, aw_got_d;
    logic                    w_got_q, w_got_d;
    logic [DATA_LEN-1:0]     waddr_q, waddr_d;
    logic [DATA_LEN-1:0]     wdata_q, wdata_d;
    logic [DATA_BIT_NUM-1:0] wstrob_q, wstrob_d;
    logic [DELAY_BITS-1:0]   wcnt_q, wcnt_d;
    logic [7:0]              wlfsr_q, wlfsr_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [2:0]              bresp_q, bresp_d;
    logic                    wr_in_range;
    logic [DEPTH_LOG2-1:0]   widx;
    logic                    aw_hs, w_hs, aw_have, w_have;
    logic                    mem_we;
    logic [DATA_LEN-1:0]     wmerge;

    assign rd_in_range = ({1'b0, raddr_q} >= ADDR_LO) && ({1'b0, raddr_q} < ADDR_HI);
    assign wr_in_range = ({1'b0, waddr_q} >= ADDR_LO) && ({1'b0, waddr_q} < ADDR_HI);
    assign ridx        = raddr_q[DEPTH_LOG2+1:2];
    assign widx        = waddr_q[DEPTH_LOG2+1:2];

    always_comb begin
        rstate_d  = rstate_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        rlfsr_d   = rlfsr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    raddr_d   = raddr;
                    rcnt_d    = RAND_DELAY ? rlfsr_q[DELAY_BITS-1:0] : '0;
                    rlfsr_d   = lfsr_step(rlfsr_q);
                    arready_d = 1'b0;
                    rstate_d  = R_DELAY;
                end
            end
            R_DELAY: begin
                if (rcnt_q != '0) begin
                    rcnt_d = rcnt_q - 1'b1;
                end else begin
                    // Combinational array read sees the pre-edge word, so a same-edge write is not visible.
                    rdata_d  = rd_in_range ? mem[ridx] : '0;
                    rresp_d  = rd_in_range ? RESP_OKAY : RESP_ERR;
                    rvalid_d = 1'b1;
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rlfsr_q   <= RD_SEED;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rlfsr_q   <= rlfsr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign aw_hs   = awvalid && awready_q;
    assign w_hs    = wvalid && wready_q;
    assign aw_have = aw_got_q || aw_hs;
    assign w_have  = w_got_q || w_hs;

    always_comb begin
        wstate_d  = wstate_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrob_d  = wstrob_q;
        wcnt_d    = wcnt_q;
        wlfsr_d   = wlfsr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    waddr_d  = waddr;
                    aw_got_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = wdata;
                    wstrob_d = wstrob;
                    w_got_d  = 1'b1;
                end
                if (aw_have && w_have) begin
                    wcnt_d    = RAND_DELAY ? wlfsr_q[DELAY_BITS-1:0] : '0;
                    wlfsr_d   = lfsr_step(wlfsr_q);
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    wstate_d  = W_DELAY;
                end else begin
                    awready_d = ~aw_have;
                    wready_d  = ~w_have;
                end
            end
            W_DELAY: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    mem_we   = wr_in_range;
                    bresp_d  = wr_in_range ? RESP_OKAY : RESP_ERR;
                    bvalid_d = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrob_q  <= '0;
            wcnt_q    <= '0;
            wlfsr_q   <= WR_SEED;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrob_q  <= wstrob_d;
            wcnt_q    <= wcnt_d;
            wlfsr_q   <= wlfsr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_comb begin
        wmerge = mem[widx];
        for (int unsigned i = 0; i < DATA_BIT_NUM; i++) begin
            if (wstrob_q[i]) wmerge[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Storage is deliberately not reset; reset holds the write FSM idle so no commit can occur.
    always_ff @(posedge clk) begin
        if (mem_we) mem[widx] <= wmerge;
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: fixed-latency instance for data paths and a random-delay
// instance for read latency, both checked against an array/LFSR reference model.
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] waddr, wdata;
    logic [3:0]  wstrob;
    logic [2:0]  bresp;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] raddr, rdata;
    logic [2:0]  rresp;
    logic        arvalid1, arready1, rvalid1, awready1, wready1, bvalid1;
    logic [31:0] rdata1;
    logic [2:0]  rresp1, bresp1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [int];

    always #5 clk = ~clk;

    axi_sram_slave #(.RAND_DELAY(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .waddr(waddr),
        .wvalid(wvalid), .wready(wready), .wstrob(wstrob), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .raddr(raddr),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
    );

    axi_sram_slave #(.RAND_DELAY(1'b1), .DELAY_BITS(3), .RD_SEED(8'h01)) dut1 (
        .clk(clk), .rst(rst),
        .awvalid(1'b0), .awready(awready1), .waddr(32'h0),
        .wvalid(1'b0), .wready(wready1), .wstrob(4'h0), .wdata(32'h0),
        .bvalid(bvalid1), .bready(1'b1), .bresp(bresp1),
        .arvalid(arvalid1), .arready(arready1), .raddr(raddr),
        .rvalid(rvalid1), .rready(rready), .rresp(rresp1), .rdata(rdata1)
    );

    // ---------------- reference model ----------------
    function automatic bit m_in_range(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_0000 + 4 * 1024);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - 32'h8000_0000) / 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_in_range(a)) return 32'h0;
        if (model_mem.exists(m_idx(a))) return model_mem[m_idx(a)];
        return 'x;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!m_in_range(a)) return;
        w = m_read(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model_mem[m_idx(a)] = w;
    endfunction

    function automatic logic [7:0] m_lfsr_next(input logic [7:0] v);
        logic fb;
        fb = ^(v & 8'b0001_1101);
        return (v >> 1) | {fb, 7'b0};
    endfunction

    // ---------------- transaction tasks ----------------
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [2:0] resp, output int lat);
        @(negedge clk);
        waddr = a; wdata = d; wstrob = s; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (bvalid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        resp = bresp;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input bit d, input logic [31:0] a,
                           output logic [31:0] data, output logic [2:0] resp, output int lat);
        @(negedge clk);
        raddr = a;
        if (d) arvalid1 = 1'b1; else arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; arvalid1 = 1'b0;
        lat = 0;
        while ((d ? rvalid1 : rvalid) !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        data = d ? rdata1 : rdata;
        resp = d ? rresp1 : rresp;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            n_bad++;
            $display("FAIL reset_hs: got %b want 11100", {arready, awready, wready, rvalid, bvalid});
        end
        n_cmp++;
        if ({rdata, rresp, bresp} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_data: got rdata=%h rresp=%b bresp=%b want zeros", rdata, rresp, bresp);
        end
        n_cmp++;
        if ({arready1, rvalid1} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_dut1: got %b want 10", {arready1, rvalid1});
        end
    endtask

    task automatic test_basic();
        logic [2:0] resp; logic [31:0] d; int lat;
        do_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, resp, lat);
        m_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF);
        n_cmp++;
        if (lat !== 1 || resp !== 3'b000) begin
            n_bad++;
            $display("FAIL basic_write: got lat=%0d resp=%b want lat=1 resp=000", lat, resp);
        end
        do_read(1'b0, 32'h8000_0004, d, resp, lat);
        n_cmp++;
        if (lat !== 1 || resp !== 3'b000 || d !== m_read(32'h8000_0004)) begin
            n_bad++;
            $display("FAIL basic_read: got lat=%0d resp=%b data=%h want lat=1 resp=000 data=%h",
                     lat, resp, d, m_read(32'h8000_0004));
        end
    endtask

    task automatic test_strobe();
        logic [2:0] resp; logic [31:0] d; int lat;
        do_write(32'h8000_0004, 32'h00AA_0000, 4'b0100, resp, lat);
        m_write(32'h8000_0004, 32'h00AA_0000, 4'b0100);
        do_read(1'b0, 32'h8000_0006, d, resp, lat);
        n_cmp++;
        if (d !== 32'hDEAA_BEEF || d !== m_read(32'h8000_0004) || resp !== 3'b000) begin
            n_bad++;
            $display("FAIL strobe: got data=%h resp=%b want data=deaabeef resp=000", d, resp);
        end
        do_write(32'h8000_0004, 32'h1234_5678, 4'b0000, resp, lat);
        do_read(1'b0, 32'h8000_0004, d, resp, lat);
        n_cmp++;
        if (d !== m_read(32'h8000_0004) || resp !== 3'b000) begin
            n_bad++;
            $display("FAIL strobe_zero: got data=%h resp=%b want data=%h resp=000",
                     d, resp, m_read(32'h8000_0004));
        end
    endtask

    task automatic test_skew();
        logic [2:0] resp; logic [31:0] d, a; int lat, bad_rdy;
        for (int ord = 0; ord < 2; ord++) begin
            a = 32'h8000_0010 + 32'(ord * 4);
            d = $urandom();
            @(negedge clk);
            waddr = a; wdata = d; wstrob = 4'hF;
            if (ord == 0) wvalid = 1'b1; else awvalid = 1'b1;
            @(posedge clk); #1;
            wvalid = 1'b0; awvalid = 1'b0;
            bad_rdy = 0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (ord == 0 && (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0)) bad_rdy++;
                if (ord == 1 && (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0)) bad_rdy++;
                if (c == 3) begin
                    if (ord == 0) awvalid = 1'b1; else wvalid = 1'b1;
                end
            end
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0;
            lat = 0;
            while (bvalid !== 1'b1 && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            resp = bresp;
            @(posedge clk); #1;
            m_write(a, d, 4'hF);
            n_cmp++;
            if (bad_rdy !== 0 || lat !== 1 || resp !== 3'b000) begin
                n_bad++;
                $display("FAIL skew_%0d: got ready_errs=%0d lat=%0d resp=%b want 0 1 000",
                         ord, bad_rdy, lat, resp);
            end
            do_read(1'b0, a, d, resp, lat);
            n_cmp++;
            if (d !== m_read(a)) begin
                n_bad++;
                $display("FAIL skew_data_%0d: got %h want %h", ord, d, m_read(a));
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [5];
        logic [2:0] resp, exp_resp; logic [31:0] d, wd; int lat;
        addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0FFC; addrs[2] = 32'h0000_1000;
        addrs[3] = 32'h8000_1000; addrs[4] = 32'h7FFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            wd = $urandom();
            exp_resp = m_in_range(addrs[i]) ? 3'b000 : 3'b010;
            do_write(addrs[i], wd, 4'hF, resp, lat);
            m_write(addrs[i], wd, 4'hF);
            n_cmp++;
            if (resp !== exp_resp) begin
                n_bad++;
                $display("FAIL oor_bresp_%0d: got %b want %b", i, resp, exp_resp);
            end
        end
        for (int i = 0; i < 5; i++) begin
            exp_resp = m_in_range(addrs[i]) ? 3'b000 : 3'b010;
            do_read(1'b0, addrs[i], d, resp, lat);
            n_cmp++;
            if (resp !== exp_resp || d !== m_read(addrs[i])) begin
                n_bad++;
                $display("FAIL oor_read_%0d: got data=%h resp=%b want data=%h resp=%b",
                         i, d, resp, m_read(addrs[i]), exp_resp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0; int lat, bad;
        rready = 1'b0;
        @(negedge clk);
        raddr = 32'h8000_0004; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        d0 = rdata;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) bad++;
        end
        n_cmp++;
        if (lat !== 1 || bad !== 0 || d0 !== m_read(32'h8000_0004)) begin
            n_bad++;
            $display("FAIL rd_backpressure: got lat=%0d unstable=%0d data=%h want 1 0 %h",
                     lat, bad, d0, m_read(32'h8000_0004));
        end
        rready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_release: got rvalid=%b arready=%b want 0 1", rvalid, arready);
        end
        bready = 1'b0;
        @(negedge clk);
        waddr = 32'h8000_0030; wdata = 32'hA5A5_5A5A; wstrob = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        m_write(32'h8000_0030, 32'hA5A5_5A5A, 4'hF);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bvalid !== 1'b1 || bresp !== 3'b000 || awready !== 1'b0 || wready !== 1'b0) bad++;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bad !== 0 || bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_backpressure: got unstable=%0d bvalid=%b awready=%b wready=%b want 0 0 1 1",
                     bad, bvalid, awready, wready);
        end
    endtask

    task automatic test_random();
        int pool [8];
        logic [31:0] a, d, exp_d; logic [3:0] s; logic [2:0] resp, exp_resp; int lat;
        for (int k = 0; k < 8; k++) begin
            pool[k] = $urandom_range(0, 1023);
            a = 32'h8000_0000 + 32'(pool[k] * 4);
            d = $urandom();
            do_write(a, d, 4'hF, resp, lat);
            m_write(a, d, 4'hF);
        end
        for (int op = 0; op < 60; op++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom() & 32'h7FFF_FFFF;
            else a = 32'h8000_0000 + 32'(pool[$urandom_range(0, 7)] * 4) + 32'($urandom_range(0, 3));
            exp_resp = m_in_range(a) ? 3'b000 : 3'b010;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom();
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, resp, lat);
                m_write(a, d, s);
                n_cmp++;
                if (resp !== exp_resp || lat !== 1) begin
                    n_bad++;
                    $display("FAIL rand_write_%0d: addr=%h got resp=%b lat=%0d want %b 1",
                             op, a, resp, lat, exp_resp);
                end
            end else begin
                exp_d = m_read(a);
                do_read(1'b0, a, d, resp, lat);
                n_cmp++;
                if (resp !== exp_resp || lat !== 1 || d !== exp_d) begin
                    n_bad++;
                    $display("FAIL rand_read_%0d: addr=%h got data=%h resp=%b lat=%0d want %h %b 1",
                             op, a, d, resp, lat, exp_d, exp_resp);
                end
            end
        end
    endtask

    task automatic test_rand_delay();
        logic [7:0] lf; logic [31:0] d; logic [2:0] resp; int lat, exp_lat;
        lf = 8'h01;
        for (int i = 0; i < 16; i++) begin
            exp_lat = 1 + int'(lf[2:0]);
            lf = m_lfsr_next(lf);
            do_read(1'b1, 32'h8000_0000 + 32'($urandom_range(0, 1023) * 4), d, resp, lat);
            n_cmp++;
            if (lat !== exp_lat || resp !== 3'b000) begin
                n_bad++;
                $display("FAIL rand_delay_%0d: got lat=%0d resp=%b want lat=%0d resp=000",
                         i, lat, resp, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old, d; logic [2:0] resp; int lat, seen;
        do_write(32'h8000_0020, 32'h0BAD_F00D, 4'hF, resp, lat);
        m_write(32'h8000_0020, 32'h0BAD_F00D, 4'hF);
        old = m_read(32'h8000_0020);
        @(negedge clk);
        raddr = 32'h8000_0040; arvalid1 = 1'b1;
        waddr = 32'h8000_0020; wdata = ~old; wstrob = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        arvalid1 = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rvalid1, arready1, bvalid, awready, wready} !== 5'b01011) begin
            n_bad++;
            $display("FAIL reset_async: got %b want 01011", {rvalid1, arready1, bvalid, awready, wready});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rvalid1 !== 1'b0 || bvalid !== 1'b0 || arready1 !== 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_abandon: got %0d bad cycles want 0", seen);
        end
        do_read(1'b0, 32'h8000_0020, d, resp, lat);
        n_cmp++;
        if (d !== old) begin
            n_bad++;
            $display("FAIL reset_no_commit: got %h want %h", d, old);
        end
        do_read(1'b1, 32'h8000_0000, d, resp, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL reset_seed_lat: got %0d want 2", lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; arvalid1 = 1'b0;
        waddr = '0; wdata = '0; wstrob = '0; raddr = '0;
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_strobe();
        test_skew();
        test_out_of_range();
        test_backpressure();
        test_random();
        test_rand_delay();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
